// File: rtl/rsa_ctrl_pkg.sv
// Shared constants for the RSA UART sequencer: state encodings, error word fill, watchdog default.
package rsa_ctrl_pkg;

    localparam logic [2:0] LOAD_BASE = 3'd0;
    localparam logic [2:0] LOAD_EXP  = 3'd1;
    localparam logic [2:0] LOAD_MOD  = 3'd2;
    localparam logic [2:0] START     = 3'd3;
    localparam logic [2:0] WAIT      = 3'd4;
    localparam logic [2:0] SEND      = 3'd5;
    localparam logic [2:0] DRAIN     = 3'd6;

    // Error word is this bit replicated across the full result width
    localparam logic ERR_FILL = 1'b1;

    localparam int unsigned DEF_TIMEOUT_CYC = 32'd16777216;

endpackage

// File: rtl/rsa_uart_ctrl.sv
// Sequencer: collects base/exp/mod words, runs the RSA engine, hands the result to the serialiser.
// Optional WAIT watchdog enabled by defining RSA_CTRL_TIMEOUT_EN.
module rsa_uart_ctrl
    import rsa_ctrl_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 2
`ifdef RSA_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_rx_valid,
    input  logic [N-1:0] i_rx_bytes,
    output logic [N-1:0] o_op_base,
    output logic [N-1:0] o_op_exp,
    output logic [N-1:0] o_op_mod,
    output logic         o_eng_start,
    input  logic         i_eng_done,
    input  logic [N-1:0] i_eng_result,
    output logic [N-1:0] o_tx_bytes,
    output logic         o_tx_valid,
    input  logic         i_tx_busy,
    output logic         o_busy,
    output logic         o_overrun,
`ifdef RSA_CTRL_TIMEOUT_EN
    output logic         o_timeout,
`endif
    output logic [2:0]   o_state_dbg
);

    localparam logic [CNT_W-1:0] SLOT_BASE = CNT_W'(0);
    localparam logic [CNT_W-1:0] SLOT_EXP  = CNT_W'(1);
    localparam logic [CNT_W-1:0] SLOT_MOD  = CNT_W'(2);

    logic [2:0]       r_state;
    logic [2:0]       w_state_d;
    logic [CNT_W-1:0] r_slot;
    logic [N-1:0]     r_op_base;
    logic [N-1:0]     r_op_exp;
    logic [N-1:0]     r_op_mod;
    logic [N-1:0]     r_tx_bytes;
    logic             r_overrun;
    logic             r_drain_first;
    logic             w_loading;
    logic             w_take_done;
    logic             w_wd_hit;

`ifdef RSA_CTRL_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic        r_timeout;

    assign w_wd_hit  = (r_wd_cnt == TIMEOUT_CYC - 32'd1);
    assign o_timeout = r_timeout;

    // Counter is cleared while in START so it starts from zero on WAIT entry
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == WAIT) begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
            end else begin
                r_wd_cnt <= '0;
            end
            if (r_state == WAIT && !i_eng_done && w_wd_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_wd_hit = 1'b0;
`endif

    assign w_loading   = (r_state == LOAD_BASE) || (r_state == LOAD_EXP) ||
                         (r_state == LOAD_MOD);
    assign w_take_done = (r_state == WAIT) && i_eng_done;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            LOAD_BASE: if (i_rx_valid) w_state_d = LOAD_EXP;
            LOAD_EXP:  if (i_rx_valid) w_state_d = LOAD_MOD;
            LOAD_MOD:  if (i_rx_valid) w_state_d = START;
            START:     w_state_d = WAIT;
            WAIT:      if (i_eng_done || w_wd_hit) w_state_d = SEND;
            SEND:      if (!i_tx_busy) w_state_d = DRAIN;
            // Serialiser raises busy one cycle after the load strobe, so ignore the first cycle
            DRAIN:     if (!r_drain_first && !i_tx_busy) w_state_d = LOAD_BASE;
            default:   w_state_d = LOAD_BASE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= LOAD_BASE;
            r_slot        <= SLOT_BASE;
            r_op_base     <= '0;
            r_op_exp      <= '0;
            r_op_mod      <= '0;
            r_tx_bytes    <= '0;
            r_overrun     <= 1'b0;
            r_drain_first <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_drain_first <= (r_state == SEND) && !i_tx_busy;
            if (i_rx_valid && w_loading) begin
                if (r_slot == SLOT_BASE) begin
                    r_op_base <= i_rx_bytes;
                end else if (r_slot == SLOT_EXP) begin
                    r_op_exp <= i_rx_bytes;
                end else begin
                    r_op_mod <= i_rx_bytes;
                end
                r_slot <= (r_slot == SLOT_MOD) ? SLOT_BASE : r_slot + CNT_W'(1);
            end
            if (i_rx_valid && !w_loading) begin
                r_overrun <= 1'b1;
            end
            if (w_take_done) begin
                r_tx_bytes <= i_eng_result;
            end else if (r_state == WAIT && w_wd_hit) begin
                r_tx_bytes <= {N{ERR_FILL}};
            end
        end
    end

    assign o_op_base   = r_op_base;
    assign o_op_exp    = r_op_exp;
    assign o_op_mod    = r_op_mod;
    assign o_tx_bytes  = r_tx_bytes;
    assign o_overrun   = r_overrun;
    assign o_eng_start = (r_state == START);
    assign o_tx_valid  = (r_state == SEND) && !i_tx_busy;
    assign o_busy      = (r_state != LOAD_BASE);
    assign o_state_dbg = r_state;

endmodule

// File: doc/rsa_uart_ctrl.md
Name: rsa_uart_ctrl

Overview:
- Sequencer between the UART word path and an RSA modular-exponentiation engine.
- Collects three N-bit words from serial_to_parallel in a fixed order: base, exponent, modulus.
- Latches them onto the engine operand buses, pulses engine start and waits for done.
- Hands the N-bit result to parallel_to_serial and waits for its serialisation to finish before accepting the next job.

Parameters:
- N, 32, operand/result word width in bits.
- CNT_W, 2, width of the word-slot counter (enough to count 3 words).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe from serial_to_parallel: rx_bytes holds a complete word.
- rx_bytes  in  N  assembled word from serial_to_parallel.
- op_base  out  N  engine base operand.
- op_exp  out  N  engine exponent operand.
- op_mod  out  N  engine modulus operand.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_done  in  1  one-cycle completion strobe from engine.
- eng_result  in  N  engine result, valid in the eng_done cycle.
- tx_bytes  out  N  word to parallel_to_serial.
- tx_valid  out  1  one-cycle load strobe to parallel_to_serial.
- tx_busy  in  1  high while parallel_to_serial is shifting bytes out.
- busy  out  1  high in every state except LOAD_BASE.
- overrun  out  1  sticky: a word arrived while not loading.
- state_dbg  out  3  current state encoding, for LEDs.

Behaviour:
- Reset values: all operand buses and tx_bytes 0; eng_start, tx_valid, busy, overrun 0; state LOAD_BASE.
- Reset mid-operation aborts the job. Any later eng_done is ignored until the next START.

States and transitions:
- LOAD_BASE: on rx_valid, op_base<=rx_bytes, go to LOAD_EXP.
- LOAD_EXP: on rx_valid, op_exp<=rx_bytes, go to LOAD_MOD.
- LOAD_MOD: on rx_valid, op_mod<=rx_bytes, go to START.
- START: eng_start=1 for exactly this cycle, go to WAIT. Operands are stable from this cycle until leaving WAIT.
- WAIT: on eng_done, tx_bytes<=eng_result, go to SEND. eng_done in any other state is ignored.
- SEND: if tx_busy=0, tx_valid=1 for this one cycle, go to DRAIN. Otherwise hold in SEND.
- DRAIN: skip the first cycle; parallel_to_serial raises tx_busy the cycle after tx_valid. Then go to LOAD_BASE when tx_busy=0.

Latency and handshakes:
- Last word rx_valid to eng_start: 1 cycle.
- eng_done to tx_valid: 1 cycle if tx_busy is low.
- rx_valid outside LOAD_* states: word discarded, overrun<=1. overrun is cleared only by rst.
- rx_valid and eng_done in the same cycle in WAIT: eng_done is taken, word is dropped, overrun is set.
- A modulus of zero is still passed to the engine. Result handling is the engine's concern.
- No arithmetic inside this block. All widths are exactly N; no truncation.

Optional Feature:
- Macro: RSA_CTRL_TIMEOUT_EN.
- With the macro defined:
  - Parameter TIMEOUT_CYC (default 2^24) and output timeout (1 bit, sticky, rst-cleared) are added.
  - A counter runs while in WAIT and clears on entry to WAIT.
  - If it reaches TIMEOUT_CYC without eng_done: timeout<=1, tx_bytes<={N{1'b1}}, go to SEND, so the host receives an all-ones error word.
- Without the macro: no counter and no timeout port; WAIT is unbounded.

Decomposition:
- Shared package rsa_ctrl_pkg holds:
  - state encoding localparams: LOAD_BASE=0, LOAD_EXP=1, LOAD_MOD=2, START=3, WAIT=4, SEND=5, DRAIN=6;
  - the error-word constant;
  - the default TIMEOUT_CYC.
- Single module, no sub-module required. The optional watchdog counter may be a small rsa_ctrl_watchdog instance if reused elsewhere.

Test Plan:
- Nominal job: send words 0x00000004, 0x0000000D, 0x000001F1. Model engine returns 0x000001BD after 50 cycles. Require:
  - eng_start exactly once, 1 cycle after the 3rd rx_valid, with operands as sent;
  - tx_valid once with tx_bytes=0x000001BD;
  - return to LOAD_BASE after tx_busy falls.
- Back-pressure: hold tx_busy=1 when eng_done arrives -> tx_valid stays 0; it asserts the cycle after tx_busy drops.
- Overrun: rx_valid=1 during WAIT with 0xDEADBEEF -> overrun=1, operands unchanged, job result still sent.
- Reset mid-job: assert rst in WAIT, then deliver eng_done -> no tx_valid, state LOAD_BASE, all outputs 0. The next three words start a fresh job.
- Stray done: eng_done in LOAD_EXP -> no state change, no tx_valid.
- RSA_CTRL_TIMEOUT_EN, TIMEOUT_CYC=100, engine never answers -> timeout=1 and tx_valid with tx_bytes=0xFFFFFFFF, both 101 cycles after eng_start.
